// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from 1-bit full-add cells, with an
// optional output register stage and a valid qualifier travelling alongside.
module full_adder #(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid
);

    logic [WIDTH-1:0] ci_c;
    logic [WIDTH-1:0] s_c;
    logic [WIDTH-1:0] co_c;

    // Ripple chain: each cell's carry-in is the previous cell's carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == 0) begin : g_first
            assign ci_c[i] = c;
        end else begin : g_next
            assign ci_c[i] = co_c[i-1];
        end
        assign s_c[i]  = a[i] ^ b[i] ^ ci_c[i];
        assign co_c[i] = (a[i] & b[i]) | (a[i] & ci_c[i]) | (b[i] & ci_c[i]);
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q, sum_d;
        logic [WIDTH-1:0] carry_q, carry_d;
        logic             vld_q, vld_d;

        // Load only on a qualified cycle so unqualified operands never reach the outputs.
        always_comb begin
            sum_d   = sum_q;
            carry_d = carry_q;
            vld_d   = in_valid;
            if (in_valid) begin
                sum_d   = s_c;
                carry_d = co_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
                vld_q   <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                vld_q   <= vld_d;
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign c_out     = carry_q[WIDTH-1];
        assign out_valid = vld_q;
    end else begin : g_comb
        assign sum       = s_c;
        assign carry     = co_c;
        assign c_out     = co_c[WIDTH-1];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// Randomised and directed bench for full_adder (WIDTH=4, REG_OUT=1).
module tb_full_adder;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] sum, carry;
    logic         c_out, out_valid;

    int comp = 0;
    int mism = 0;

    // expected registered state
    logic [W-1:0] e_sum, e_carry;
    logic         e_cout;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(W), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c),
        .sum(sum), .c_out(c_out), .carry(carry), .out_valid(out_valid)
    );

    // Arithmetic reference: total of the operands, truncated to W+1 bits.
    function automatic logic [W:0] ref_total(int unsigned x, int unsigned y, int unsigned z);
        int unsigned t;
        t = x + y + z;
        return t[W:0];
    endfunction

    // carry[i] is the carry out of the low (i+1)-bit partial sum.
    function automatic logic [W-1:0] ref_carry(int unsigned x, int unsigned y, int unsigned z);
        logic [W-1:0] r;
        int unsigned m, t;
        for (int i = 0; i < W; i++) begin
            m = (32'd1 << (i + 1)) - 1;
            t = ((x & m) + (y & m) + z) >> (i + 1);
            r[i] = t[0];
        end
        return r;
    endfunction

    function automatic void set_expect(int unsigned x, int unsigned y, int unsigned z);
        logic [W:0] t;
        t       = ref_total(x, y, z);
        e_sum   = t[W-1:0];
        e_cout  = t[W];
        e_carry = ref_carry(x, y, z);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = 1'b0;
        #12;
        comp++;
        if ({sum, c_out, carry, out_valid} !== '0) begin
            mism++;
            $display("FAIL reset: got sum=%b c_out=%b carry=%b vld=%b, want all 0", sum, c_out, carry, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        comp++;
        if (out_valid !== 1'b0) begin
            mism++;
            $display("FAIL reset_release_vld: got %b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1111};
        logic [W-1:0] tb [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b1111};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] ws [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b1111};
        logic         wo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] wc [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = ta[i]; b = tb[i]; c = tc[i];
            @(negedge clk);
            in_valid = 1'b0;
            comp++;
            if (sum !== ws[i] || c_out !== wo[i] || carry !== wc[i] || out_valid !== 1'b1) begin
                mism++;
                $display("FAIL directed%0d: got sum=%b c_out=%b carry=%b vld=%b, want sum=%b c_out=%b carry=%b vld=1",
                         i + 1, sum, c_out, carry, out_valid, ws[i], wo[i], wc[i]);
            end
        end
        // full ripple: all-ones + 0 + 1
        @(negedge clk);
        in_valid = 1'b1; a = '1; b = '0; c = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        comp++;
        if (sum !== '0 || c_out !== 1'b1 || carry !== '1) begin
            mism++;
            $display("FAIL full_ripple: got sum=%b c_out=%b carry=%b, want 0000/1/1111", sum, c_out, carry);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned qa [$], qb [$], qc [$];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                set_expect(qa[i-1], qb[i-1], qc[i-1]);
                comp++;
                if (sum !== e_sum || c_out !== e_cout || carry !== e_carry || out_valid !== 1'b1) begin
                    mism++;
                    $display("FAIL b2b%0d: got sum=%h c_out=%b carry=%b vld=%b, want sum=%h c_out=%b carry=%b vld=1",
                             i - 1, sum, c_out, carry, out_valid, e_sum, e_cout, e_carry);
                end
            end
            if (i < 4) begin
                qa.push_back($urandom_range(0, 15));
                qb.push_back($urandom_range(0, 15));
                qc.push_back($urandom_range(0, 1));
                in_valid = 1'b1; a = qa[i][W-1:0]; b = qb[i][W-1:0]; c = qc[i][0];
            end else begin
                in_valid = 1'b0; a = ~a; b = $urandom_range(0, 15); c = ~c;
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
            comp++;
            if (sum !== e_sum || c_out !== e_cout || carry !== e_carry || out_valid !== 1'b0) begin
                mism++;
                $display("FAIL hold%0d: got sum=%h c_out=%b carry=%b vld=%b, want sum=%h c_out=%b carry=%b vld=0",
                         k, sum, c_out, carry, out_valid, e_sum, e_cout, e_carry);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid = 1'b1; a = 4'hF; b = 4'hF; c = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        comp++;
        if ({sum, c_out, carry, out_valid} !== '0) begin
            mism++;
            $display("FAIL mid_reset: got sum=%b c_out=%b carry=%b vld=%b, want all 0", sum, c_out, carry, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'h7; b = 4'h5; c = 1'b1;
        set_expect(7, 5, 1);
        @(negedge clk);
        in_valid = 1'b0;
        comp++;
        if (sum !== e_sum || c_out !== e_cout || carry !== e_carry || out_valid !== 1'b1) begin
            mism++;
            $display("FAIL resume: got sum=%h c_out=%b carry=%b vld=%b, want sum=%h c_out=%b carry=%b vld=1",
                     sum, c_out, carry, out_valid, e_sum, e_cout, e_carry);
        end
    endtask

    task automatic test_exhaustive();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 2; z++) begin
                    @(negedge clk);
                    in_valid = 1'b1; a = x[W-1:0]; b = y[W-1:0]; c = z[0];
                    set_expect(x, y, z);
                    @(negedge clk);
                    in_valid = 1'b0;
                    comp++;
                    if (sum !== e_sum || c_out !== e_cout || carry !== e_carry || out_valid !== 1'b1) begin
                        mism++;
                        $display("FAIL exh a=%h b=%h c=%0d: got sum=%h c_out=%b carry=%b vld=%b, want sum=%h c_out=%b carry=%b",
                                 x, y, z, sum, c_out, carry, out_valid, e_sum, e_cout, e_carry);
                    end
                end
    endtask

    task automatic test_random();
        logic v, ev;
        int unsigned x, y, z;
        ev = 1'b0;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                comp++;
                if (sum !== e_sum || c_out !== e_cout || carry !== e_carry || out_valid !== ev) begin
                    mism++;
                    $display("FAIL rand%0d: got sum=%h c_out=%b carry=%b vld=%b, want sum=%h c_out=%b carry=%b vld=%b",
                             i, sum, c_out, carry, out_valid, e_sum, e_cout, e_carry, ev);
                end
            end
            v = ($urandom_range(0, 3) != 0);
            x = $urandom_range(0, 15); y = $urandom_range(0, 15); z = $urandom_range(0, 1);
            in_valid = v; a = x[W-1:0]; b = y[W-1:0]; c = z[0];
            if (v) set_expect(x, y, z);
            ev = v;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, mism);
        $finish;
    end
endmodule
